// File: rtl/exc_ctrl_if.sv
// Signal bundle between the pipeline (master) and the exception controller (slave).
// Iv qualifies Ovr/Unimpl/Syscall in the same cycle; Intr and Eret are sampled every cycle, no back-pressure.
interface exc_ctrl_if;
    logic        Intr;
    logic        Ovr;
    logic        Unimpl;
    logic        Syscall;
    logic        Iv;
    logic        Eret;
    logic [3:0]  Sta;
    logic [31:0] Cause;
    logic        Wcau;
    logic        Wsta;
    logic        Wepc;
    logic        StaSel;
    logic [1:0]  Selpc;
    logic        Inta;
    logic        Busy;
    logic [1:0]  DbgState;
    logic        DbgPend;

    modport master (
        output Intr, Ovr, Unimpl, Syscall, Iv, Eret, Sta,
        input  Cause, Wcau, Wsta, Wepc, StaSel, Selpc, Inta, Busy, DbgState, DbgPend
    );

    modport slave (
        input  Intr, Ovr, Unimpl, Syscall, Iv, Eret, Sta,
        output Cause, Wcau, Wsta, Wepc, StaSel, Selpc, Inta, Busy, DbgState, DbgPend
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: IDLE -> ENTER -> HANDLER -> RETURN with fixed-priority event selection.
// Optional macro INTR_SYNC_EN inserts a two-flop synchronizer on Intr.
module exc_ctrl (
    input  logic       Clk,
    input  logic       Rst,
    exc_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        HANDLER = 2'd2,
        RETURN  = 2'd3
    } state_t;

    localparam logic [4:0] CODE_INT = 5'd0;
    localparam logic [4:0] CODE_SYS = 5'd8;
    localparam logic [4:0] CODE_UNI = 5'd10;
    localparam logic [4:0] CODE_OVR = 5'd12;

    state_t     state_q;
    logic       pend_q, pend_d;
    logic [4:0] exc_q;
    logic       wcau_q, wsta_q, wepc_q, stasel_q, inta_q;
    logic [1:0] selpc_q;
    logic       intr_s;
    logic       intr_cand;
    logic       take, take_intr;
    logic [4:0] code_d;

`ifdef INTR_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.Intr};
        end
    end

    // The synchronized level is also a direct candidate so the request is taken one cycle before pend shows it.
    assign intr_s    = sync_q[1];
    assign intr_cand = pend_q | intr_s;
`else
    assign intr_s    = bus.Intr;
    assign intr_cand = pend_q;
`endif

    always_comb begin
        take      = 1'b1;
        take_intr = 1'b0;
        code_d    = CODE_INT;
        if (bus.Iv && bus.Ovr && bus.Sta[3]) begin
            code_d = CODE_OVR;
        end else if (bus.Iv && bus.Unimpl && bus.Sta[2]) begin
            code_d = CODE_UNI;
        end else if (bus.Iv && bus.Syscall && bus.Sta[1]) begin
            code_d = CODE_SYS;
        end else if (intr_cand && bus.Sta[0]) begin
            take_intr = 1'b1;
        end else begin
            take = 1'b0;
        end
        if (state_q != IDLE) begin
            take      = 1'b0;
            take_intr = 1'b0;
        end
        pend_d = take_intr ? 1'b0 : (pend_q | intr_s);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            exc_q    <= 5'd0;
            wcau_q   <= 1'b0;
            wsta_q   <= 1'b0;
            wepc_q   <= 1'b0;
            stasel_q <= 1'b0;
            selpc_q  <= 2'b00;
            inta_q   <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            wcau_q   <= 1'b0;
            wsta_q   <= 1'b0;
            wepc_q   <= 1'b0;
            stasel_q <= 1'b0;
            selpc_q  <= 2'b00;
            inta_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take) begin
                        state_q <= ENTER;
                        exc_q   <= code_d;
                        wcau_q  <= 1'b1;
                        wsta_q  <= 1'b1;
                        wepc_q  <= 1'b1;
                        selpc_q <= 2'b11;
                        inta_q  <= take_intr;
                    end
                end
                ENTER: state_q <= HANDLER;
                HANDLER: begin
                    if (bus.Eret) begin
                        state_q  <= RETURN;
                        wsta_q   <= 1'b1;
                        stasel_q <= 1'b1;
                        selpc_q  <= 2'b10;
                    end
                end
                RETURN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Cause    = {25'd0, exc_q, 2'b00};
    assign bus.Wcau     = wcau_q;
    assign bus.Wsta     = wsta_q;
    assign bus.Wepc     = wepc_q;
    assign bus.StaSel   = stasel_q;
    assign bus.Selpc    = selpc_q;
    assign bus.Inta     = inta_q;
    assign bus.Busy     = (state_q != IDLE);
    assign bus.DbgState = state_q;
    assign bus.DbgPend  = pend_q;
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port Rst, input, 1, synchronous active-high reset sampled on Clk rising edge.
REQ-003 SHALL have port Intr, input, 1, external interrupt request, level, asynchronous to Clk when INTR_SYNC_EN is defined.
REQ-004 SHALL have ports Ovr, Unimpl, Syscall, input, 1 each, exception flags of the current instruction.
REQ-005 SHALL have port Iv, input, 1, current instruction valid; the flags in REQ-004 are ignored when Iv=0.
REQ-006 SHALL have port Eret, input, 1, ERET decoded and valid.
REQ-007 SHALL have port Sta, input, 4, mask bits: Sta[0] intr, Sta[1] syscall, Sta[2] unimpl, Sta[3] ovr; 1 = enabled.
REQ-008 SHALL have port Cause, output, 32, value for the cause register: ExcCode in [6:2], all other bits 0.
REQ-009 SHALL have ports Wcau, Wsta, Wepc, output, 1 each, write enables for the cause, status and EPC registers.
REQ-010 SHALL have port StaSel, output, 1, status update select: 0 = shift-left-4 on entry, 1 = shift-right-4 on return.
REQ-011 SHALL have port Selpc, output, 2, PC override: 00 none, 10 EPC, 11 exception vector.
REQ-012 SHALL have port Inta, output, 1, interrupt acknowledge, one-cycle pulse.
REQ-013 SHALL have port Busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, ENTER, HANDLER and RETURN, with all outputs registered or decoded from state.
REQ-015 SHALL keep a pending flag pend that is set when the (synchronized) Intr is high and cleared only when ENTER is entered for an interrupt.
REQ-016 SHALL take an event in IDLE only; candidates are Iv&Ovr&Sta[3], Iv&Unimpl&Sta[2], Iv&Syscall&Sta[1] and pend&Sta[0].
REQ-017 SHALL apply fixed priority Ovr > Unimpl > Syscall > interrupt when several candidates are active in the same cycle.
REQ-018 SHALL use ExcCode values: interrupt 0, syscall 8, unimpl 10, ovr 12; examples Cause=0x00000000, 0x00000020, 0x00000028, 0x00000030.
REQ-019 SHALL latch the ExcCode into Cause on the IDLE->ENTER edge and hold it until the next event is taken.
REQ-020 SHALL produce the following during the single ENTER cycle, then go to HANDLER: Wcau=Wsta=Wepc=1, StaSel=0, Selpc=11, and Inta=1 only if the event is an interrupt.
REQ-021 SHALL ignore all exception flags and pend in HANDLER, so that no nesting occurs; pend stays set and is serviced after return.
REQ-022 SHALL go to RETURN when Eret=1 in HANDLER; the RETURN cycle asserts Wsta=1, StaSel=1 and Selpc=10, and then goes to IDLE.
REQ-023 SHALL ignore Eret in IDLE, ENTER and RETURN.
REQ-024 SHALL take a synchronous exception that becomes enabled at cycle N in IDLE such that ENTER is at N+1 (latency 1).
REQ-025 SHALL keep pend set while Sta[0]=0 and take it once Sta[0]=1 in IDLE.
REQ-026 SHALL drive Wcau, Wsta, Wepc, Inta=0 and Selpc=00 in IDLE and HANDLER.

Reset
REQ-027 SHALL, when Rst=1 at a clock edge in any state (including mid-ENTER or RETURN), give state=IDLE, pend=0, synchronizer flops=0, Cause=0, Selpc=00, StaSel=0, and all enables, Inta and Busy=0.
REQ-028 SHALL give Rst priority over every event in the same cycle.

Configuration
REQ-029 SHALL, when INTR_SYNC_EN is defined, pass Intr through a two-flop synchronizer before pend; the interrupt ENTER then occurs at N+3 for Intr rising at N with Sta[0]=1 in IDLE.
REQ-030 SHALL, without INTR_SYNC_EN, feed Intr directly to pend; ENTER then occurs at N+2.

Verification
REQ-031 SHALL cover: Iv=1, Ovr=1, Sta=4'hF in IDLE -> next cycle Cause=0x00000030, Wcau=Wsta=Wepc=1, Selpc=11, Inta=0.
REQ-032 SHALL cover: Ovr, Syscall and pend all active in one cycle with Sta=4'hF -> Cause=0x00000030; pend remains set; the interrupt (Cause=0x00000000, Inta=1) is taken after ERET and RETURN.
REQ-033 SHALL cover: Intr=1 with Sta[0]=0 for 10 cycles -> no ENTER; Sta[0]=1 -> ENTER next cycle with Inta=1 and pend cleared.
REQ-034 SHALL cover: Eret in HANDLER -> one cycle with Wsta=1, StaSel=1, Selpc=10, then IDLE with Busy=0; Eret in IDLE -> no output change.
REQ-035 SHALL cover: Rst=1 asserted during ENTER -> next cycle all outputs 0 and state IDLE.
REQ-036 SHALL cover: Syscall with Iv=0 -> ignored; the same pattern with Iv=1 and Sta[1]=1 -> Cause=0x00000020.
